col_sum_resolver: RTL and testbench

//  Final stage of the compressor-based multiplier datapath. Consumes one column

---
 rtl/col_sum_resolver.sv | 108 ++++++++++
 tb/tb_col_sum_resolver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/col_sum_resolver.sv
// Serial carry resolver for compressor column counts: turns LSB-first per-column
// weights into a binary product word and hands it off over valid/ready.
module col_sum_resolver #(
  parameter int COLS  = 8,
  parameter int CNT_W = 3,
  parameter int P_W   = COLS + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] col_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   p_data,
  output logic             busy,
  output logic             err
);

  localparam int IDX_W = $clog2(P_W);
  localparam int T_W   = ((CNT_W > 3) ? CNT_W : 3) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       carry_q, carry_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [P_W-1:0]   acc_q,   acc_d;
  logic             err_q,   err_d;

  logic             accept;
  logic             illegal;
  logic [T_W-1:0]   t_sum;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign accept    = in_valid & in_ready;
  assign illegal   = col_cnt > CNT_W'(4);
  assign t_sum     = T_W'(col_cnt) + T_W'(carry_q);

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ACCUM) || (state_q == S_FLUSH);
  assign p_data    = acc_q;
  assign err       = err_q;

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latches).
    state_d = state_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d[idx_q] = t_sum[0];
          carry_d      = 3'(t_sum >> 1);
          idx_d        = idx_q + IDX_W'(1);
          // The first column of a frame clears whatever error the previous frame left behind.
          err_d        = (state_q == S_IDLE) ? illegal : (err_q | illegal);
          state_d      = (idx_q == IDX_W'(COLS - 1)) ? S_FLUSH : S_ACCUM;
        end
      end
      S_FLUSH: begin
        // idx keeps walking past COLS, so the three carry bits land in the top of acc.
        acc_d[idx_q] = carry_q[0];
        carry_d      = carry_q >> 1;
        if (idx_q == IDX_W'(P_W - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          idx_d   = '0;
          carry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      carry_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_col_sum_resolver.sv
// Bench for col_sum_resolver: directed frames on a 4-column instance and a
// randomized handshake run on an 8-column instance against a weighted-sum model.
module tb_col_sum_resolver;

  localparam int COLS_A = 4;
  localparam int P_A    = COLS_A + 3;
  localparam int COLS_B = 8;
  localparam int P_B    = COLS_B + 3;
  localparam int NF     = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_err;
  logic [2:0]     a_col_cnt;
  logic [P_A-1:0] a_p_data;

  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_err;
  logic [2:0]     b_col_cnt;
  logic [P_B-1:0] b_p_data;

  int total = 0;
  int bad   = 0;

  col_sum_resolver #(.COLS(COLS_A), .CNT_W(3), .P_W(P_A)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .col_cnt(a_col_cnt),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .p_data(a_p_data),
    .busy(a_busy), .err(a_err)
  );

  col_sum_resolver #(.COLS(COLS_B), .CNT_W(3), .P_W(P_B)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .col_cnt(b_col_cnt),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .p_data(b_p_data),
    .busy(b_busy), .err(b_err)
  );

  // Reference: the product is simply the sum of each count times its column weight.
  function automatic int wsum4(input int c0, input int c1, input int c2, input int c3);
    return c0 + 2 * c1 + 4 * c2 + 8 * c3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int c0, input int c1, input int c2, input int c3);
    int cs[4];
    cs = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      int w = 0;
      a_in_valid = 1'b1;
      a_col_cnt  = 3'(cs[i]);
      while (a_in_ready !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      if (w == 20) begin
        total++; bad++;
        $display("FAIL send_a in_ready stuck low at column %0d", i);
      end
      step();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_done_a(output int lat);
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_a();
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL handshake out_valid got=%0b exp=0", a_out_valid);
    end
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL handshake in_ready got=%0b exp=1", a_in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_col_cnt = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_col_cnt = '0; b_out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", a_busy); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", a_err); end
    total++; if (a_p_data !== '0) begin bad++; $display("FAIL reset_p_data got=%0d exp=0", a_p_data); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reset_b_in_ready got=%0b exp=1", b_in_ready); end
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_b_out_valid got=%0b exp=0", b_out_valid); end
    total++; if (b_p_data !== '0) begin bad++; $display("FAIL reset_b_p_data got=%0d exp=0", b_p_data); end
  endtask

  task automatic test_frames();
    int tbl[4][4];
    tbl = '{'{4, 4, 4, 4}, '{1, 0, 0, 0}, '{0, 0, 0, 4}, '{3, 2, 1, 4}};
    for (int f = 0; f < 4; f++) begin
      int lat;
      int exp_p;
      exp_p = wsum4(tbl[f][0], tbl[f][1], tbl[f][2], tbl[f][3]);
      send_a(tbl[f][0], tbl[f][1], tbl[f][2], tbl[f][3]);
      total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL frame%0d busy_in_flush got=%0b exp=1", f, a_busy); end
      wait_done_a(lat);
      total++; if (lat != 3) begin bad++; $display("FAIL frame%0d latency got=%0d exp=3", f, lat); end
      total++; if (a_p_data !== 7'(exp_p)) begin bad++; $display("FAIL frame%0d p_data got=%0d exp=%0d", f, a_p_data, exp_p); end
      total++; if (a_err !== 1'b0) begin bad++; $display("FAIL frame%0d err got=%0b exp=0", f, a_err); end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL frame%0d in_ready_in_done got=%0b exp=0", f, a_in_ready); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL frame%0d busy_in_done got=%0b exp=0", f, a_busy); end
      finish_a();
    end
  endtask

  task automatic test_hold();
    int lat;
    send_a(3, 2, 1, 4);
    wait_done_a(lat);
    // Offer a column while the result is stalled; it must not be taken before the handshake.
    a_in_valid = 1'b1;
    a_col_cnt  = 3'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL hold%0d out_valid got=%0b exp=1", i, a_out_valid); end
      total++; if (a_p_data !== 7'(wsum4(3, 2, 1, 4))) begin bad++; $display("FAIL hold%0d p_data got=%0d exp=43", i, a_p_data); end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL hold%0d in_ready got=%0b exp=0", i, a_in_ready); end
    end
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL hold_no_early_accept busy got=%0b exp=0", a_busy); end
    send_a(2, 2, 2, 2);
    wait_done_a(lat);
    total++; if (a_p_data !== 7'(wsum4(2, 2, 2, 2))) begin bad++; $display("FAIL hold_next p_data got=%0d exp=30", a_p_data); end
    finish_a();
  endtask

  task automatic test_illegal();
    int lat;
    send_a(5, 0, 0, 0);
    wait_done_a(lat);
    total++; if (a_p_data !== 7'(wsum4(5, 0, 0, 0))) begin bad++; $display("FAIL illegal p_data got=%0d exp=5", a_p_data); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL illegal err_in_done got=%0b exp=1", a_err); end
    finish_a();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL illegal err_in_idle got=%0b exp=1", a_err); end
    a_in_valid = 1'b1;
    a_col_cnt  = 3'd1;
    step();
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL illegal err_after_next_accept got=%0b exp=0", a_err); end
    a_col_cnt = 3'd0;
    for (int i = 0; i < 3; i++) step();
    a_in_valid = 1'b0;
    wait_done_a(lat);
    total++; if (a_p_data !== 7'(wsum4(1, 0, 0, 0))) begin bad++; $display("FAIL illegal_next p_data got=%0d exp=1", a_p_data); end
    finish_a();
  endtask

  task automatic test_reset_mid();
    int lat;
    a_in_valid = 1'b1;
    a_col_cnt  = 3'd3;
    step();
    a_col_cnt  = 3'd1;
    step();
    a_in_valid = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rst_mid busy_before got=%0b exp=1", a_busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid in_ready got=%0b exp=1", a_in_ready); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%0b exp=0", a_busy); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid spurious out_valid cycle %0d", i); end
    end
    send_a(2, 2, 2, 2);
    wait_done_a(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL rst_mid latency got=%0d exp=3", lat); end
    total++; if (a_p_data !== 7'(wsum4(2, 2, 2, 2))) begin bad++; $display("FAIL rst_mid p_data got=%0d exp=30", a_p_data); end
    finish_a();
  endtask

  task automatic test_random();
    int exp_q[$];
    fork
      begin : driver
        for (int f = 0; f < NF; f++) begin
          int cs[COLS_B];
          int exp_p = 0;
          for (int i = 0; i < COLS_B; i++) begin
            cs[i] = int'($urandom_range(4));
            exp_p += cs[i] << i;
          end
          exp_q.push_back(exp_p);
          for (int i = 0; i < COLS_B; i++) begin
            int w = 0;
            if ($urandom_range(3) == 0) begin
              b_in_valid = 1'b0;
              step();
            end
            b_in_valid = 1'b1;
            b_col_cnt  = 3'(cs[i]);
            while (b_in_ready !== 1'b1 && w < 200) begin
              step();
              w++;
            end
            if (w == 200) begin
              $display("FAIL random in_ready stuck low frame %0d", f);
              $fatal(1, "random driver stalled");
            end
            step();
          end
          b_in_valid = 1'b0;
        end
      end
      begin : monitor
        int got = 0;
        int cyc = 0;
        while (got < NF && cyc < 80000) begin
          b_out_ready = 1'($urandom_range(1));
          total++;
          if (b_in_ready === 1'b1 && b_out_valid === 1'b1) begin
            bad++; $display("FAIL random in_ready_and_out_valid cycle %0d", cyc);
          end
          if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            int exp_p;
            exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            total++;
            if (b_p_data !== 11'(exp_p) || exp_p < 0) begin
              bad++; $display("FAIL random p_data frame %0d got=%0d exp=%0d", got, b_p_data, exp_p);
            end
            total++;
            if (b_err !== 1'b0) begin
              bad++; $display("FAIL random err frame %0d got=%0b exp=0", got, b_err);
            end
            got++;
          end
          step();
          cyc++;
        end
        b_out_ready = 1'b0;
        total++;
        if (got != NF) begin
          bad++; $display("FAIL random frames got=%0d exp=%0d", got, NF);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_frames();
    test_hold();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
